// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory port, decode handshake, redirect and halt status.
interface instruction_fetch_if #(
    parameter int unsigned ADDR_WIDTH = 16
) ();
    logic                  imem_en;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_rdata;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [31:0]           instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  halted;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_rdata,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc,
        input  redirect_valid,
        input  redirect_pc,
        output halted
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_rdata,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc,
        output redirect_valid,
        output redirect_pc,
        input  halted
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads a 1-cycle synchronous imem and queues {word, pc}
// in a 2-entry FIFO toward decode; handles redirects and stops after a HALT word.
module instruction_fetch #(
    parameter int unsigned           ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [5:0]            HALT_OPCODE = 6'h3F
) (
    input  logic                clk,
    input  logic                rst_n,
    instruction_fetch_if.master bus
);
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned OPC_WIDTH  = 6;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] word;
        logic [ADDR_WIDTH-1:0] pc;
    } fifo_entry_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] infl_pc_q, infl_pc_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [1:0]            count_q, count_d;
    fifo_entry_t           fifo_q [FIFO_DEPTH];

    logic                  valid_c;
    logic                  pop_c;
    logic                  capture_c;
    logic                  halt_hit_c;
    logic                  issue_c;
    logic [2:0]            occupancy_c;

    // Next-state, handshake and issue decisions
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inflight_d  = 1'b0;
        infl_pc_d   = infl_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;

        valid_c     = (count_q != 2'd0) && !bus.redirect_valid;
        pop_c       = valid_c && bus.instr_ready;
        capture_c   = inflight_q && !bus.redirect_valid;
        halt_hit_c  = capture_c &&
                      (bus.imem_rdata[DATA_WIDTH-1 -: OPC_WIDTH] == HALT_OPCODE);
        // Slots already committed once this cycle's pop is taken into account
        occupancy_c = 3'(count_q) + 3'(inflight_q) - 3'(pop_c);
        issue_c     = rst_n && (state_q == RUN) && !bus.redirect_valid &&
                      (occupancy_c < 3'(FIFO_DEPTH));

        if (issue_c) begin
            infl_pc_d = pc_q;
        end

        if (bus.redirect_valid) begin
            state_d  = RUN;
            pc_d     = bus.redirect_pc;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            inflight_d = issue_c && !halt_hit_c;
            rd_ptr_d   = rd_ptr_q ^ pop_c;
            wr_ptr_d   = wr_ptr_q ^ capture_c;
            count_d    = count_q + 2'(capture_c) - 2'(pop_c);
            if (halt_hit_c) begin
                state_d = HALTED;
                pc_d    = infl_pc_q + ADDR_WIDTH'(1);
            end else if (issue_c) begin
                pc_d = pc_q + ADDR_WIDTH'(1);
            end
        end
    end

    // State and FIFO registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            infl_pc_q  <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            infl_pc_q  <= infl_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            if (capture_c) begin
                fifo_q[wr_ptr_q] <= {bus.imem_rdata, infl_pc_q};
            end
        end
    end

    assign bus.imem_en     = issue_c;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = valid_c;
    assign bus.instr       = fifo_q[rd_ptr_q].word;
    assign bus.instr_pc    = fifo_q[rd_ptr_q].pc;
    assign bus.halted      = (state_q == HALTED);
endmodule
